// File: rtl/gmii_rx_mac_if.sv
// Byte-wide AXI-Stream lane carrying received frame payload.
// No tready: the sink accepts every beat.
interface gmii_rx_mac_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser);
    modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/gmii_rx_mac.sv
// GMII receive MAC front-end: strips preamble/SFD and FCS, checks CRC and
// length, streams payload bytes with a per-frame bad flag and frame counters.
module gmii_rx_mac #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1522,
    parameter int CNT_W     = 32
) (
    input  logic             gmii_rxc,
    input  logic             rst,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rd,
    gmii_rx_mac_if.master    m_axis,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames
);
    localparam logic [7:0]  PRE         = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_CNT     = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_CNT     = 16'(MAX_FRAME);
    localparam logic [15:0] HOLD_CNT    = 16'd5;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q;
    logic [15:0] cnt_q;
    logic        err_q;
    logic [39:0] dly_q;
    logic        load;
    logic        beat;
    logic        beat_last;
    logic        beat_user;
    logic        inc_good;
    logic        inc_bad;
    logic        frame_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    // Running CRC over data+FCS lands on the fixed residue for a clean frame.
    assign frame_bad = err_q | (crc_q != CRC_RESIDUE) | (cnt_q < MIN_CNT);

    always_ff @(posedge gmii_rxc or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        beat      = 1'b0;
        beat_last = 1'b0;
        beat_user = 1'b0;
        inc_good  = 1'b0;
        inc_bad   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rd == PRE)      state_d = PREAMBLE;
                    else if (gmii_rd == SFD) state_d = PAYLOAD;
                    else                     state_d = DROP;
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv)         state_d = IDLE;
                else if (gmii_rd == SFD) state_d = PAYLOAD;
                else if (gmii_rd != PRE) state_d = DROP;
            end
            PAYLOAD: begin
                if (gmii_rx_dv) begin
                    load = 1'b1;
                    if (cnt_q == MAX_CNT) begin
                        beat      = 1'b1;
                        beat_last = 1'b1;
                        beat_user = 1'b1;
                        inc_bad   = 1'b1;
                        state_d   = DROP;
                    end else if (cnt_q >= HOLD_CNT) begin
                        beat = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    if (cnt_q >= HOLD_CNT) begin
                        beat      = 1'b1;
                        beat_last = 1'b1;
                        beat_user = frame_bad;
                    end
                    if (cnt_q < HOLD_CNT || frame_bad) inc_bad  = 1'b1;
                    else                               inc_good = 1'b1;
                end
            end
            DROP: begin
                if (!gmii_rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gmii_rxc or posedge rst) begin
        if (rst) begin
            crc_q         <= '1;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            dly_q         <= '0;
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
            good_frames   <= '0;
            bad_frames    <= '0;
        end else begin
            // Frame state is rearmed whenever we are outside a payload.
            if (state_q != PAYLOAD) begin
                crc_q <= '1;
                cnt_q <= '0;
                err_q <= 1'b0;
            end else if (load) begin
                crc_q <= crc_byte(crc_q, gmii_rd);
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                if (gmii_rx_er) err_q <= 1'b1;
                dly_q <= {dly_q[31:0], gmii_rd};
            end
            m_axis.tvalid <= beat;
            m_axis.tdata  <= beat ? dly_q[39:32] : 8'h00;
            m_axis.tlast  <= beat_last;
            m_axis.tuser  <= beat_user;
            if (inc_good) good_frames <= good_frames + CNT_W'(1);
            if (inc_bad)  bad_frames  <= bad_frames + CNT_W'(1);
        end
    end
endmodule

// File: doc/gmii_rx_mac.md
Name: gmii_rx_mac

Overview:
- Receive MAC front-end. Consumes the GMII receive side (gmii_rxc, gmii_rx_dv, gmii_rx_er, gmii_rd) produced by the RGMII PHY adapter.
- Strips preamble/SFD, checks and strips FCS, emits frame payload as a byte-wide AXI-Stream with per-frame error flag.
- Maintains good/bad frame counters for status registers.
- Runs entirely in the gmii_rxc domain; downstream is an async FIFO (no backpressure).

Parameters:
- MIN_FRAME, 64, minimum legal frame length in bytes, counted from first byte after SFD through FCS.
- MAX_FRAME, 1522, maximum legal frame length in bytes, same counting.
- CNT_W, 32, width of frame counters.

Ports:
- gmii_rxc  input  1  receive clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- gmii_rx_dv  input  1  GMII data valid.
- gmii_rx_er  input  1  GMII receive error.
- gmii_rd  input  8  GMII receive data.
- m_axis_tdata  output  8  payload byte.
- m_axis_tvalid  output  1  byte valid. No tready; the sink must accept every beat.
- m_axis_tlast  output  1  last payload byte of frame.
- m_axis_tuser  output  1  frame bad. Meaningful only with tlast.
- good_frames  output  CNT_W  count of frames ended with tuser=0.
- bad_frames  output  CNT_W  count of frames ended with tuser=1, plus silently dropped short frames.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, CRC register 0xFFFFFFFF, byte count 0, error flag 0, pipeline empty. Reset mid-frame aborts the frame without emitting tlast. The next frame needs dv low then a fresh preamble.
- States: IDLE, PREAMBLE, PAYLOAD, DROP.
- IDLE:
  - dv=1 & rd=0x55 -> PREAMBLE.
  - dv=1 & rd=0xD5 -> PAYLOAD (zero-length preamble accepted).
  - dv=1 & any other rd -> DROP.
- PREAMBLE:
  - dv=1 & rd=0x55 -> stay.
  - dv=1 & rd=0xD5 -> PAYLOAD; clear CRC, count and error flag.
  - dv=1 & other rd -> DROP.
  - dv=0 -> IDLE, with no output and no counter change.
- PAYLOAD, each cycle with dv=1:
  - Byte enters a 5-byte delay line: 4 FCS-candidate bytes plus 1 pending byte.
  - Byte enters the CRC: reflected poly 0xEDB88320, LSB-first, one byte per cycle.
  - count increments, saturating at 16 bits.
  - er=1 sets the error flag.
- Emission: once count ≥5, each new byte outputs the pending byte with tvalid=1, tlast=0. Latency is 5 cycles from gmii_rd sample to m_axis_tdata.
- End of frame: the first edge in PAYLOAD sampling dv=0 produces:
  - If count ≥5: pending byte out with tvalid=1, tlast=1.
  - tuser = error flag | (CRC reg ≠ 0xDEBB20E3) | (count < MIN_FRAME).
  - The matching counter increments.
  - If count <5: no beat; bad_frames increments.
  - FSM -> IDLE.
- Oversize: the byte that makes count = MAX_FRAME+1 causes emission of the pending byte with tlast=1, tuser=1, increments bad_frames, and moves the FSM to DROP. Nothing further is emitted for that frame.
- DROP: ignore input until dv=0 sampled, then -> IDLE. No output.
- tvalid is high for exactly one cycle per beat. tdata/tlast/tuser are 0 when tvalid=0.
- Back-to-back: one idle cycle (dv=0) between frames is sufficient. The tlast beat and the next frame's first preamble byte never conflict.
- Counters wrap modulo 2^CNT_W.
- gmii_rx_er with dv=0 (carrier extension/false carrier) is ignored.

Test Plan:
- Good frame: 7×0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS, then dv low → 60 beats 0x00..0x3B. tlast on 0x3B with tuser=0; first beat 5 cycles after its input byte; good_frames=1.
- Bad FCS: same frame with last FCS byte XOR 0x01 → 60 beats, tlast tuser=1, bad_frames=1, good_frames unchanged.
- rx_er and runt:
  - Valid 64-byte frame with gmii_rx_er=1 for one payload cycle → tuser=1.
  - Valid-CRC 40-byte frame → 36 beats, tuser=1.
  - 3-byte frame → no beats, bad_frames+1.
- Oversize, MAX_FRAME=1522, 1600-byte frame → 1518 beats, tlast/tuser=1 on beat 1518, no further beats until next frame.
- Back-to-back with one-cycle IPG: two good 64-byte frames → 120 beats, two tlast, good_frames=2.
- Mid-frame reset: assert rst during payload → outputs 0 immediately. Remainder of frame ignored; next good frame counted as good_frames=1.
- Bad preamble byte 0x5A → no output, no counter change.
